// File: rtl/fetch_buffer_pkg.sv
// Shared entry geometry for the fetch buffer and its neighbours.
package fetch_buffer_pkg;

  localparam int BRANCH_TAKEN_W  = 1;
  localparam int BRANCH_ADDR_W   = 32;
  localparam int ID_W            = 4;
  localparam int INSTR_W         = 32;
  localparam int PC_W            = 32;
  localparam int IQ_ENTRY_SIZE   = BRANCH_TAKEN_W + BRANCH_ADDR_W + ID_W + INSTR_W + PC_W;
  localparam int NUM_IQ_ENTRIES  = 8;

  // Issue queue free count clipped to the two push slots we can use.
  function automatic logic [1:0] sat2(input logic [3:0] v);
    return (v >= 4'd2) ? 2'd2 : v[1:0];
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and issue-queue-side handshake bundle of the fetch buffer.
interface fetch_buffer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = fetch_buffer_pkg::IQ_ENTRY_SIZE
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_vld0;
  logic [WIDTH-1:0] in_data0;
  logic             in_vld1;
  logic [WIDTH-1:0] in_data1;
  logic             in_rdy;
  logic [3:0]       iq_free;
  logic             push0;
  logic [WIDTH-1:0] push_data0;
  logic             push1;
  logic [WIDTH-1:0] push_data1;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_vld0, in_data0, in_vld1, in_data1, iq_free,
    input  in_rdy, push0, push_data0, push1, push_data1, count
  );

  modport slave (
    input  flush, in_vld0, in_data0, in_vld1, in_data1, iq_free,
    output in_rdy, push0, push_data0, push1, push_data1, count
  );

endinterface

// File: rtl/fetch_buffer_mem.sv
// Entry storage: two write ports, two asynchronous read ports.
module fetch_buffer_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata0,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The two write addresses are always distinct consecutive slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// 2-wide in-order decoupling FIFO between fetch and the issue queue.
// Optional same-cycle forwarding when FETCH_BUFFER_BYPASS_EN is defined.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = IQ_ENTRY_SIZE
) (
  input logic         clk,
  input logic         rst_n,
  fetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    tot;
  logic             in_rdy;
  logic [1:0]       n_in, free2, avail, n_push, n_pop, used_in, n_wr;
  logic [WIDTH-1:0] rdata0, rdata1, wdata0;
  logic [WIDTH-1:0] data0, data1;

  assign in_rdy = !bus.flush && (occ <= CW'(DEPTH - 2));

  // Pushes draw from a virtual queue: stored entries first, then (with
  // forwarding) this cycle's incoming entries; whatever is not pushed is stored.
  always_comb begin
    n_in = 2'd0;
    if (in_rdy && bus.in_vld0) n_in = bus.in_vld1 ? 2'd2 : 2'd1;
    free2   = sat2(bus.iq_free);
    tot     = BYPASS ? (occ + CW'(n_in)) : occ;
    avail   = (tot >= CW'(2)) ? 2'd2 : tot[1:0];
    n_push  = bus.flush ? 2'd0 : ((free2 < avail) ? free2 : avail);
    n_pop   = (occ >= CW'(n_push)) ? n_push : occ[1:0];
    used_in = n_push - n_pop;
    n_wr    = n_in - used_in;
    wdata0  = (used_in == 2'd0) ? bus.in_data0 : bus.in_data1;
  end

  always_comb begin
    data0 = '0;
    data1 = '0;
    if (n_push != 2'd0) data0 = (occ != '0) ? rdata0 : bus.in_data0;
    if (n_push == 2'd2) begin
      if (occ >= CW'(2))      data1 = rdata1;
      else if (occ == CW'(1)) data1 = bus.in_data0;
      else                    data1 = bus.in_data1;
    end
  end

  fetch_buffer_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we0    (n_wr != 2'd0),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (n_wr == 2'd2),
    .waddr1 (wr_ptr + PW'(1)),
    .wdata1 (bus.in_data1),
    .raddr0 (rd_ptr),
    .raddr1 (rd_ptr + PW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_pop);
      wr_ptr <= wr_ptr + PW'(n_wr);
      occ    <= occ + CW'(n_wr) - CW'(n_pop);
    end
  end

  assign bus.in_rdy     = in_rdy;
  assign bus.push0      = (n_push != 2'd0);
  assign bus.push1      = (n_push == 2'd2);
  assign bus.push_data0 = data0;
  assign bus.push_data1 = data1;
  assign bus.count      = occ;

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- 2-wide decoupling FIFO between instruction fetch/decode and the issue queue.
- Accepts up to two packed entries per cycle from fetch: {branch_taken, branch_taken_address, id, instruction, pc}, IQ_ENTRY_SIZE bits.
- Drives the issue queue push0/push_data0/push1/push_data1 interface, throttled by the queue's 4-bit free count.
- Flush discards all buffered entries; entries leave in strict program order.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- WIDTH, `IQ_ENTRY_SIZE, bits per entry.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; discard all buffered and incoming entries.
- in_vld0  in  1  fetch slot 0 valid.
- in_data0  in  WIDTH  fetch slot 0 entry.
- in_vld1  in  1  fetch slot 1 valid; only legal with in_vld0.
- in_data1  in  WIDTH  fetch slot 1 entry, younger than slot 0.
- in_rdy  out  1  buffer can accept two entries this cycle.
- iq_free  in  4  free slot count reported by the issue queue (0..8).
- push0  out  1  present oldest entry to the issue queue.
- push_data0  out  WIDTH  oldest entry.
- push1  out  1  present second-oldest entry.
- push_data1  out  WIDTH  second-oldest entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, storage cleared. Outputs: push0=0, push1=0, push_data0/1=0, in_rdy=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Slot pointer +1 also wraps (DEPTH-1 -> 0).
- in_rdy = !flush && (count <= DEPTH-2). Combinational from registered count only, with no dependence on iq_free.
- Enqueue is all-or-nothing per cycle.
  - With in_rdy, in_vld0 writes slot wr_ptr.
  - in_vld1 writes slot wr_ptr+1.
  - wr_ptr advances by in_vld0 + (in_vld0 & in_vld1).
  - in_vld1 without in_vld0 is ignored and writes nothing.
- Dequeue:
  - push0 = !flush && count>=1 && iq_free>=1.
  - push1 = !flush && count>=2 && iq_free>=2.
  - push1 implies push0.
  - push_data0 = mem[rd_ptr], push_data1 = mem[rd_ptr+1]. When the matching push is 0, drive 0.
  - The issue queue accepts unconditionally when its free count allows, so no acknowledge is needed. rd_ptr advances by push0+push1 in the same cycle.
- Latency: an entry written at edge N is presentable in the cycle after edge N (1-cycle minimum) when the optional feature is absent.
- count_next = count + enq0 + enq1 - push0 - push1. Compute at $clog2(DEPTH)+1 bits.
  - Never exceeds DEPTH, because in_rdy needs 2 free slots.
  - Never underflows, because push gating depends on count.
- Simultaneous enqueue and dequeue in the same cycle is legal in all combinations, including full-occupancy turnover. Example: count=6, enqueue 2 and push 2 gives count=6.
- Flush (synchronous, highest priority):
  - At the next edge: rd_ptr=0, wr_ptr=0, count=0.
  - Incoming entries in the flush cycle are dropped, and no pushes are issued in the flush cycle.
  - Storage contents need not be cleared.
- Reset asserted mid-operation clears state immediately, regardless of clock. First pushes can occur only after a post-reset enqueue.
- iq_free values above 8 are not produced. Any value >=2 permits both pushes.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined:
  - When count==0 and flush==0, incoming in_data0/in_data1 are forwarded combinationally to push_data0/push_data1 in the same cycle.
  - push0 = in_vld0 && iq_free>=1; push1 = in_vld0 && in_vld1 && iq_free>=2.
  - Forwarded entries that are pushed are not stored. Entries that cannot be pushed are stored in order.
  - When count==1, slot 0 comes from storage and slot 1 is forwarded from in_data0, under the same rules.
- Undefined: no forwarding. Minimum latency is 1 cycle as above.

Decomposition:
- Shared defines header (existing defines.vh) holds `IQ_ENTRY_SIZE, `NUM_IQ_ENTRIES and the entry field widths. No new typedefs.
- Sub-module fetch_buffer_mem: DEPTH x WIDTH register array with two write ports and two read ports (addresses, write enables) and asynchronous read. Pointers, count and push logic stay in fetch_buffer.

Test Plan:
- Reset, then in_vld0=in_vld1=1 with A/B and iq_free=8 -> next cycle push0=push1=1 with A then B; count goes 2 -> 0.
- Fill with iq_free=0 over 4 cycles of 2 entries -> count=8, in_rdy=0. A fifth pair is not accepted and count stays 8.
- With count=8, iq_free=1 -> push0=1, push1=0. Oldest entry leaves, count=7, in_rdy=0. Order is preserved across the wrap at rd_ptr=7 -> 0.
- With count=6, enqueue 2 while iq_free=8 -> push 2. count stays 6 and wr_ptr wraps 6 -> 0.
- With count=5, flush plus in_vld0=1 -> next cycle count=0 and push0=0. Nothing from the flush cycle appears later.
- Assert rst_n low mid-cycle with count=3 -> push0/push1 drop to 0 asynchronously, count=0.
- With FETCH_BUFFER_BYPASS_EN defined, count=0, iq_free=1, inputs A/B -> push0 with A in the same cycle. B is stored, count=1.
